// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, side encoding, move FSM states and
// the ownership classifier used by the move controller.
package chess_pkg;

   localparam logic [3:0] EMPTY    = 4'h0;
   localparam logic [3:0] W_PAWN   = 4'h1;
   localparam logic [3:0] W_KNIGHT = 4'h2;
   localparam logic [3:0] W_BISHOP = 4'h3;
   localparam logic [3:0] W_ROOK   = 4'h4;
   localparam logic [3:0] W_QUEEN  = 4'h5;
   localparam logic [3:0] W_KING   = 4'h6;
   localparam logic [3:0] B_PAWN   = 4'h7;
   localparam logic [3:0] B_KNIGHT = 4'h8;
   localparam logic [3:0] B_BISHOP = 4'h9;
   localparam logic [3:0] B_ROOK   = 4'hA;
   localparam logic [3:0] B_QUEEN  = 4'hB;
   localparam logic [3:0] B_KING   = 4'hC;

   typedef enum logic {
      WHITE = 1'b0,
      BLACK = 1'b1
   } side_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SRC_WAIT  = 3'd1,
      SRC_CHECK = 3'd2,
      HOLD      = 3'd3,
      DST_WAIT  = 3'd4,
      DST_CHECK = 3'd5
   } move_state_t;

   function automatic logic is_empty(input logic [3:0] code);
      return code == EMPTY;
   endfunction

   // Codes D..F are neither side's piece.
   function automatic logic is_piece(input logic [3:0] code);
      return (code >= W_PAWN) && (code <= B_KING);
   endfunction

   function automatic side_t piece_side(input logic [3:0] code);
      return (code >= B_PAWN) ? BLACK : WHITE;
   endfunction

   function automatic logic is_own(input logic [3:0] code, input side_t side);
      return is_piece(code) && (piece_side(code) == side);
   endfunction

   function automatic logic is_opponent(input logic [3:0] code, input side_t side);
      return is_piece(code) && (piece_side(code) != side);
   endfunction

endpackage

// File: rtl/move_controller.sv
// Turns board clicks into pick/place commands with side-to-move ownership checks.
// Click to command is 3 cycles; cancel to place is 1; inputs arriving while busy are dropped.
module move_controller
   import chess_pkg::*;
#(
   parameter int MOVE_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  click,
   input  logic [5:0]            cursor_xy,
   input  logic                  cancel,
   input  logic [3:0]            figure_code,
   output logic [5:0]            figure_xy,
   output logic [5:0]            figure_position,
   output logic                  pick_piece,
   output logic                  place_piece,
   output logic                  turn,
   output logic                  holding,
   output logic [5:0]            src_xy,
   output logic                  capture,
   output logic                  illegal,
   output logic [MOVE_CNT_W-1:0] move_count
);

   move_state_t state;
   side_t       side;

   assign side = side_t'(turn);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         figure_xy       <= '0;
         figure_position <= '0;
         pick_piece      <= 1'b0;
         place_piece     <= 1'b0;
         turn            <= 1'b0;
         holding         <= 1'b0;
         src_xy          <= '0;
         capture         <= 1'b0;
         illegal         <= 1'b0;
         move_count      <= '0;
      end else begin
         pick_piece  <= 1'b0;
         place_piece <= 1'b0;
         capture     <= 1'b0;
         illegal     <= 1'b0;

         case (state)
            IDLE: begin
               if (click) begin
                  figure_xy <= cursor_xy;
                  src_xy    <= cursor_xy;
                  state     <= SRC_WAIT;
               end
            end

            SRC_WAIT: state <= SRC_CHECK;

            SRC_CHECK: begin
               if (is_own(figure_code, side)) begin
                  pick_piece      <= 1'b1;
                  figure_position <= src_xy;
                  holding         <= 1'b1;
                  state           <= HOLD;
               end else begin
                  illegal <= 1'b1;
                  state   <= IDLE;
               end
            end

            HOLD: begin
               if (cancel) begin
                  place_piece     <= 1'b1;
                  figure_position <= src_xy;
                  holding         <= 1'b0;
                  state           <= IDLE;
               end else if (click) begin
                  figure_xy <= cursor_xy;
                  state     <= DST_WAIT;
               end
            end

            DST_WAIT: state <= DST_CHECK;

            DST_CHECK: begin
               // Coordinates decide first: dropping on the source is a silent undo.
               if (figure_xy == src_xy) begin
                  place_piece     <= 1'b1;
                  figure_position <= src_xy;
                  holding         <= 1'b0;
                  state           <= IDLE;
               end else if (is_empty(figure_code) || is_opponent(figure_code, side)) begin
                  place_piece     <= 1'b1;
                  capture         <= is_opponent(figure_code, side);
                  figure_position <= figure_xy;
                  holding         <= 1'b0;
                  turn            <= ~turn;
                  if (move_count != {MOVE_CNT_W{1'b1}})
                     move_count <= move_count + 1'b1;
                  state <= IDLE;
               end else begin
                  illegal <= 1'b1;
                  state   <= HOLD;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench: a registered board model in the start position drives the
// lookup port; a 2-bit counter instance shares the stimulus to exercise saturation.
module tb_move_controller;

   logic       clk;
   logic       rst_n;
   logic       click;
   logic [5:0] cursor_xy;
   logic       cancel;
   logic [3:0] figure_code;
   logic [5:0] figure_xy;
   logic [5:0] figure_position;
   logic       pick_piece;
   logic       place_piece;
   logic       turn;
   logic       holding;
   logic [5:0] src_xy;
   logic       capture;
   logic       illegal;
   logic [7:0] move_count;

   logic [5:0] figure_xy2;
   logic [5:0] figure_position2;
   logic       pick_piece2;
   logic       place_piece2;
   logic       turn2;
   logic       holding2;
   logic [5:0] src_xy2;
   logic       capture2;
   logic       illegal2;
   logic [1:0] move_count2;

   int checks = 0;
   int errors = 0;

   move_controller #(.MOVE_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .click(click), .cursor_xy(cursor_xy), .cancel(cancel),
      .figure_code(figure_code), .figure_xy(figure_xy), .figure_position(figure_position),
      .pick_piece(pick_piece), .place_piece(place_piece), .turn(turn), .holding(holding),
      .src_xy(src_xy), .capture(capture), .illegal(illegal), .move_count(move_count)
   );

   move_controller #(.MOVE_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .click(click), .cursor_xy(cursor_xy), .cancel(cancel),
      .figure_code(figure_code), .figure_xy(figure_xy2), .figure_position(figure_position2),
      .pick_piece(pick_piece2), .place_piece(place_piece2), .turn(turn2), .holding(holding2),
      .src_xy(src_xy2), .capture(capture2), .illegal(illegal2), .move_count(move_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board model: one registered lookup stage, updated by the main instance's commands.
   logic [3:0] board [64];
   logic [3:0] held;

   function automatic logic [3:0] start_code(input int idx);
      logic [3:0] back_b [8];
      logic [3:0] back_w [8];
      back_b = '{4'hA, 4'h8, 4'h9, 4'hB, 4'hC, 4'h9, 4'h8, 4'hA};
      back_w = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
      case (idx / 8)
         0:       return back_b[idx % 8];
         1:       return 4'h7;
         6:       return 4'h1;
         7:       return back_w[idx % 8];
         default: return 4'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) board[i] <= start_code(i);
         figure_code <= 4'h0;
         held        <= 4'h0;
      end else begin
         figure_code <= board[figure_xy];
         if (pick_piece) begin
            held                   <= board[figure_position];
            board[figure_position] <= 4'h0;
         end
         if (place_piece) board[figure_position] <= held;
      end
   end

   typedef struct {
      logic       is_cancel;
      logic [5:0] xy;
      int         lat;
      logic [27:0] exp;
   } vec_t;

   vec_t vecs[13];

   // {pick, place, illegal, capture, figure_position, turn, holding, move_count, count2, src_xy}
   function automatic logic [27:0] pack_exp(input logic p, input logic pl, input logic il,
         input logic cp, input logic [5:0] pos, input logic t, input logic h,
         input logic [7:0] cnt, input logic [1:0] cnt2, input logic [5:0] src);
      return {p, pl, il, cp, pos, t, h, cnt, cnt2, src};
   endfunction

   function automatic logic [27:0] observe();
      return {pick_piece, place_piece, illegal, capture, figure_position, turn, holding,
              move_count, move_count2, src_xy};
   endfunction

   function automatic vec_t mk(input logic is_c, input logic [5:0] xy, input int lat,
         input logic [27:0] e);
      vec_t v;
      v.is_cancel = is_c;
      v.xy        = xy;
      v.lat       = lat;
      v.exp       = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %07h expected %07h", name, act, exp);
      end
   endtask

   task automatic check_quiet(input string name);
      logic [3:0] pulses;
      pulses = {pick_piece, place_piece, illegal, capture};
      checks++;
      if (pulses !== 4'b0000) begin
         errors++;
         $display("FAIL %s: pulses got %04b expected 0000", name, pulses);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clk);
      click     = ~v.is_cancel;
      cancel    = v.is_cancel;
      cursor_xy = v.xy;
      @(negedge clk);
      click  = 1'b0;
      cancel = 1'b0;
      repeat (v.lat - 1) @(negedge clk);
      check($sformatf("vec%0d", idx), observe(), v.exp);
      @(negedge clk);
      check_quiet($sformatf("vec%0d_pulse_width", idx));
      repeat (2) @(negedge clk);
   endtask

   task automatic drive(input logic c, input logic [5:0] xy);
      @(negedge clk);
      click     = c;
      cursor_xy = xy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      click     = 1'b0;
      cancel    = 1'b0;
      cursor_xy = 6'h00;
      rst_n     = 1'b0;

      vecs[0]  = mk(0, 6'h34, 3, pack_exp(1, 0, 0, 0, 6'h34, 0, 1, 8'd0, 2'd0, 6'h34));
      vecs[1]  = mk(0, 6'h24, 3, pack_exp(0, 1, 0, 0, 6'h24, 1, 0, 8'd1, 2'd1, 6'h34));
      vecs[2]  = mk(0, 6'h35, 3, pack_exp(0, 0, 1, 0, 6'h24, 1, 0, 8'd1, 2'd1, 6'h35));
      vecs[3]  = mk(1, 6'h00, 1, pack_exp(0, 0, 0, 0, 6'h24, 1, 0, 8'd1, 2'd1, 6'h35));
      vecs[4]  = mk(0, 6'h0B, 3, pack_exp(1, 0, 0, 0, 6'h0B, 1, 1, 8'd1, 2'd1, 6'h0B));
      vecs[5]  = mk(0, 6'h2B, 3, pack_exp(0, 1, 0, 0, 6'h2B, 0, 0, 8'd2, 2'd2, 6'h0B));
      vecs[6]  = mk(0, 6'h33, 3, pack_exp(1, 0, 0, 0, 6'h33, 0, 1, 8'd2, 2'd2, 6'h33));
      vecs[7]  = mk(0, 6'h3C, 3, pack_exp(0, 0, 1, 0, 6'h33, 0, 1, 8'd2, 2'd2, 6'h33));
      vecs[8]  = mk(0, 6'h2B, 3, pack_exp(0, 1, 0, 1, 6'h2B, 1, 0, 8'd3, 2'd3, 6'h33));
      vecs[9]  = mk(0, 6'h0C, 3, pack_exp(1, 0, 0, 0, 6'h0C, 1, 1, 8'd3, 2'd3, 6'h0C));
      vecs[10] = mk(1, 6'h00, 1, pack_exp(0, 1, 0, 0, 6'h0C, 1, 0, 8'd3, 2'd3, 6'h0C));
      vecs[11] = mk(0, 6'h0C, 3, pack_exp(1, 0, 0, 0, 6'h0C, 1, 1, 8'd3, 2'd3, 6'h0C));
      vecs[12] = mk(0, 6'h0C, 3, pack_exp(0, 1, 0, 0, 6'h0C, 1, 0, 8'd3, 2'd3, 6'h0C));

      repeat (3) @(negedge clk);
      check("reset_state", {observe(), figure_xy}, 34'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // Black picks 0C while extra clicks land in SRC_WAIT/SRC_CHECK, then
      // drops on 1C with an extra click in DST_WAIT; the 2-bit count stays at 3.
      drive(1'b1, 6'h0C);
      drive(1'b1, 6'h1C);
      drive(1'b1, 6'h1C);
      drive(1'b0, 6'h00);
      check("ignored_src_clicks", observe(),
            pack_exp(1, 0, 0, 0, 6'h0C, 1, 1, 8'd3, 2'd3, 6'h0C));
      drive(1'b1, 6'h1C);
      drive(1'b1, 6'h3C);
      drive(1'b0, 6'h00);
      @(negedge clk);
      check("ignored_dst_clicks_saturate", observe(),
            pack_exp(0, 1, 0, 0, 6'h1C, 0, 0, 8'd4, 2'd3, 6'h0C));
      @(negedge clk);
      check_quiet("after_ignored_clicks");
      repeat (3) @(negedge clk);
      check_quiet("no_queued_clicks");

      // Reset while white is holding its pawn at 24.
      run_vec(13, mk(0, 6'h24, 3, pack_exp(1, 0, 0, 0, 6'h24, 0, 1, 8'd4, 2'd3, 6'h24)));
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_while_holding", {observe(), figure_xy}, 34'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_vec(14, mk(0, 6'h34, 3, pack_exp(1, 0, 0, 0, 6'h34, 0, 1, 8'd0, 2'd0, 6'h34)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
